// File: rtl/ysyx_23060187_muldiv.sv
// Iterative RV32M multiply/divide unit with valid/ready handshakes.
// Multiply: shift-add over WIDTH cycles. Divide: restoring, one quotient bit per cycle.
// The operands' magnitudes are processed, then the sign is fixed up in a single FIX cycle.
// Optional build macro YSYX_23060187_FAST_MUL_EN: the MUL* ops use one combinational
// 2*WIDTH multiply, so CALC lasts a single cycle. Results are identical in both builds.
module ysyx_23060187_muldiv #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] opnum1,
  input  logic [WIDTH-1:0] opnum2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             res_zero,
  output logic             res_overflow,
  output logic             div_by_zero
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] MIN_NEG  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t             state_q;
  logic [2:0]         op_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2*WIDTH-1:0] acc_q;      // mul: {product high, multiplier}; div: {remainder, quotient}
  logic [WIDTH-1:0]   a_q;        // |multiplicand| or |divisor|
  logic               neg_q;      // negate product / quotient
  logic               neg_rem_q;  // negate remainder (dividend sign)
  logic [WIDTH-1:0]   result_q;
  logic               out_valid_q, res_zero_q, ovf_q, dbz_q;

  // Accept-time decode: signedness, magnitudes and the special cases that skip CALC.
  logic             s1, s2, neg1, neg2, is_div, sp_dbz, sp_ovf, sp_hit;
  logic [WIDTH-1:0] abs1, abs2, sp_res;

  // Accept-time operand decode.
  always_comb begin
    s1 = 1'b0;
    s2 = 1'b0;
    case (op)
      3'b001, 3'b100, 3'b110: begin s1 = 1'b1; s2 = 1'b1; end
      3'b010:                 s1 = 1'b1;
      default: ;
    endcase
    neg1   = s1 & opnum1[WIDTH-1];
    neg2   = s2 & opnum2[WIDTH-1];
    abs1   = neg1 ? (~opnum1 + 1'b1) : opnum1;
    abs2   = neg2 ? (~opnum2 + 1'b1) : opnum2;
    is_div = op[2];
    sp_dbz = is_div && (opnum2 == '0);
    sp_ovf = is_div && !op[0] && (opnum1 == MIN_NEG) && (opnum2 == ALL_ONES);
    sp_hit = sp_dbz | sp_ovf;
    if (sp_dbz) sp_res = op[1] ? opnum1 : ALL_ONES;
    else        sp_res = op[1] ? '0 : opnum1;
  end

  // One iteration step for each datapath, plus the sign fix-up and result select.
  logic [WIDTH:0]     mul_sum, div_shift;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;
  logic [WIDTH-1:0]   div_sub, div_rem, quo_raw, rem_raw, quo_fix, rem_fix, fix_res;
  logic               div_ge;

  // Iteration and fix-up datapath.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};
    div_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, a_q};
    // Modulo-2^WIDTH subtraction is exact whenever div_ge holds.
    div_sub   = div_shift[WIDTH-1:0] - a_q;
    div_rem   = div_ge ? div_sub : div_shift[WIDTH-1:0];
    div_next  = {div_rem, acc_q[WIDTH-2:0], div_ge};
    prod_fix  = neg_q ? (~acc_q + 1'b1) : acc_q;
    quo_raw   = acc_q[WIDTH-1:0];
    rem_raw   = acc_q[2*WIDTH-1:WIDTH];
    quo_fix   = neg_q ? (~quo_raw + 1'b1) : quo_raw;
    rem_fix   = neg_rem_q ? (~rem_raw + 1'b1) : rem_raw;
    case (op_q)
      3'b000:                 fix_res = prod_fix[WIDTH-1:0];
      3'b001, 3'b010, 3'b011: fix_res = prod_fix[2*WIDTH-1:WIDTH];
      3'b100, 3'b101:         fix_res = quo_fix;
      default:                fix_res = rem_fix;
    endcase
  end

`ifdef YSYX_23060187_FAST_MUL_EN
  logic [2*WIDTH-1:0] fast_prod;
  assign fast_prod = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
`endif

  // Control FSM with registered result and flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      a_q         <= '0;
      neg_q       <= 1'b0;
      neg_rem_q   <= 1'b0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      res_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else if (flush) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      res_zero_q  <= 1'b0;
      ovf_q       <= 1'b0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            op_q      <= op;
            neg_q     <= neg1 ^ neg2;
            neg_rem_q <= neg1;
            if (sp_hit) begin
              result_q    <= sp_res;
              res_zero_q  <= (sp_res == '0);
              dbz_q       <= sp_dbz;
              ovf_q       <= sp_ovf & ~sp_dbz;
              out_valid_q <= 1'b1;
              state_q     <= DONE;
            end else begin
              a_q     <= abs2;
              acc_q   <= {{WIDTH{1'b0}}, abs1};
              cnt_q   <= CNT_W'(WIDTH - 1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          acc_q <= op_q[2] ? div_next : mul_next;
          if (cnt_q == '0) state_q <= FIX;
          else             cnt_q   <= cnt_q - 1'b1;
`ifdef YSYX_23060187_FAST_MUL_EN
          if (!op_q[2]) begin
            acc_q   <= fast_prod;
            cnt_q   <= '0;
            state_q <= FIX;
          end
`endif
        end
        FIX: begin
          result_q    <= fix_res;
          res_zero_q  <= (fix_res == '0);
          ovf_q       <= 1'b0;
          dbz_q       <= 1'b0;
          out_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        default: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
      endcase
    end
  end

  assign in_ready     = (state_q == IDLE);
  assign out_valid    = out_valid_q;
  assign result       = result_q;
  assign res_zero     = res_zero_q;
  assign res_overflow = ovf_q;
  assign div_by_zero  = dbz_q;

endmodule

// File: tb/tb_ysyx_23060187_muldiv.sv
// Self-checking bench for ysyx_23060187_muldiv: directed RV32M cases, backpressure,
// flush, mid-operation reset and randomized operations against a 64-bit arithmetic model.
module tb_ysyx_23060187_muldiv;
  localparam int W = 32;
`ifdef YSYX_23060187_FAST_MUL_EN
  localparam int MUL_LAT = 3;
`else
  localparam int MUL_LAT = W + 2;
`endif
  localparam int DIV_LAT = W + 2;

  logic         clk = 1'b0, rst_n = 1'b0, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]   op = '0;
  logic [W-1:0] opnum1 = '0, opnum2 = '0;
  logic         in_ready, out_valid, res_zero, res_overflow, div_by_zero;
  logic [W-1:0] result;

  int checks = 0;
  int failures = 0;

  ysyx_23060187_muldiv #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .opnum1(opnum1), .opnum2(opnum2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .res_zero(res_zero), .res_overflow(res_overflow), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from plain signed/unsigned 64-bit arithmetic.
  function automatic void model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ov, output logic dz);
    longint sa, sb, p;
    logic [63:0] up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ov = 1'b0;
    dz = 1'b0;
    r  = '0;
    case (o)
      3'd0: begin up = {32'b0, a} * {32'b0, b}; r = up[31:0]; end
      3'd1: begin p = sa * sb; r = p[63:32]; end
      3'd2: begin p = sa * longint'({32'b0, b}); r = p[63:32]; end
      3'd3: begin up = {32'b0, a} * {32'b0, b}; r = up[63:32]; end
      3'd4: if (b == 0) begin r = 32'hFFFFFFFF; dz = 1'b1; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = a; ov = 1'b1; end
            else begin p = sa / sb; r = p[31:0]; end
      3'd5: if (b == 0) begin r = 32'hFFFFFFFF; dz = 1'b1; end
            else r = a / b;
      3'd6: if (b == 0) begin r = a; dz = 1'b1; end
            else if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin r = 0; ov = 1'b1; end
            else begin p = sa % sb; r = p[31:0]; end
      default: if (b == 0) begin r = a; dz = 1'b1; end
               else r = a % b;
    endcase
  endfunction

  // One full transaction: accept, latency, result/flags, optional backpressure, hand-off.
  task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input int hold);
    logic [31:0] er;
    logic eov, edz;
    int lat, el;
    model(o, a, b, er, eov, edz);
    if (o[2] && (edz || eov)) el = 1;
    else if (o[2])            el = DIV_LAT;
    else                      el = MUL_LAT;
    lat = 0;
    while (!in_ready && lat < 100) begin @(posedge clk); #1; lat++; end
    check({tag, "/ready"}, in_ready, 1);
    op = o; opnum1 = a; opnum2 = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; op = 3'($urandom); opnum1 = $urandom; opnum2 = $urandom;
    lat = 1;
    while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    check({tag, "/latency"}, lat, el);
    check({tag, "/result"}, result, er);
    check({tag, "/flags"}, {res_zero, res_overflow, div_by_zero, in_ready},
          {(er == 0), eov, edz, 1'b0});
    repeat (hold) begin
      @(posedge clk); #1;
      check({tag, "/hold"}, {out_valid, in_ready, result, res_zero, res_overflow, div_by_zero},
            {1'b1, 1'b0, er, (er == 0), eov, edz});
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/handoff"}, {out_valid, in_ready}, 2'b01);
    $display("op=%0d a=%08h b=%08h result=%08h expected=%08h lat=%0d", o, a, b, result, er, lat);
  endtask

  initial begin
    logic seen;
    logic [2:0] ro;
    logic [31:0] ra, rb;
    #1;
    check("reset", {out_valid, in_ready, result, res_zero, res_overflow, div_by_zero},
          {1'b0, 1'b1, 32'h0, 3'b000});
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset", {out_valid, in_ready}, 2'b01);

    run_op("mul",     3'd0, 32'd7,        32'hFFFFFFFD, 0);
    run_op("mulh",    3'd1, 32'h80000000, 32'h80000000, 0);
    run_op("mulhu",   3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("mulhsu",  3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 0);
    run_op("div",     3'd4, 32'hFFFFFFF9, 32'd2,        0);
    run_op("rem",     3'd6, 32'hFFFFFFF9, 32'd2,        0);
    run_op("divu",    3'd5, 32'd100,      32'd7,        0);
    run_op("remu",    3'd7, 32'd100,      32'd7,        0);
    run_op("divu0",   3'd5, 32'd5,        32'd0,        0);
    run_op("rem0",    3'd6, 32'd5,        32'd0,        0);
    run_op("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 0);
    run_op("bp_div",  3'd4, 32'hFFFF0000, 32'd3,        10);
    run_op("bp_next", 3'd1, 32'h12345678, 32'h9ABCDEF0, 0);
    run_op("bp_dz",   3'd7, 32'd9,        32'd0,        10);

    // Flush at CALC iteration 5: op discarded, flags from the last op cleared.
    op = 3'd4; opnum1 = 32'd100; opnum2 = 32'd7; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush/state", {out_valid, in_ready, result, res_zero, res_overflow, div_by_zero},
          {1'b0, 1'b1, 32'h0, 3'b000});
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (out_valid) seen = 1'b1; end
    check("flush/no_valid", seen, 1'b0);

    // Flush in IDLE with a request present: not accepted.
    op = 3'd5; opnum1 = 32'd5; opnum2 = 32'd0; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    check("flush_idle", {out_valid, in_ready, div_by_zero}, 3'b010);
    $display("flush tests done");

    run_op("after_flush", 3'd6, 32'hFFFFFF00, 32'd7, 0);

    // Asynchronous reset in the middle of CALC.
    op = 3'd0; opnum1 = 32'h00012345; opnum2 = 32'h00000777; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid", {out_valid, in_ready, result, res_zero, res_overflow, div_by_zero},
          {1'b0, 1'b1, 32'h0, 3'b000});
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    $display("mid-op reset done");
    run_op("after_rst", 3'd0, 32'h00012345, 32'h00000777, 0);

    // Randomized operations with boundary-biased operands.
    for (int i = 0; i < 150; i++) begin
      ro = 3'($urandom);
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: ra = 32'h0;
        3: rb = 32'($urandom_range(1, 15));
        4: ra = 32'h80000000;
        default: ;
      endcase
      run_op("rand", ro, ra, rb, (i % 10 == 0) ? 2 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
